// File: rtl/dev_bus_xbar_if.sv
// Host- and device-side signal bundle for dev_bus_xbar.
// The crossbar takes the slave modport; the surrounding hosts and devices take master.
interface dev_bus_xbar_if #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NR_HOSTS = 2,
  parameter int unsigned NR_DEVS  = 3
);
  // Host side
  logic [NR_HOSTS-1:0]          host_req_i;
  logic [NR_HOSTS*XLEN-1:0]     host_addr_i;
  logic [NR_HOSTS-1:0]          host_we_i;
  logic [NR_HOSTS*XLEN/8-1:0]   host_be_i;
  logic [NR_HOSTS*XLEN-1:0]     host_wdata_i;
  logic [NR_HOSTS-1:0]          host_gnt_o;
  logic [NR_HOSTS-1:0]          host_rvalid_o;
  logic [NR_HOSTS-1:0]          host_err_o;
  logic [XLEN-1:0]              host_rdata_o;
  // Device side
  logic [NR_DEVS-1:0]           dev_req_o;
  logic [XLEN-1:0]              dev_addr_o;
  logic [XLEN-1:0]              dev_wdata_o;
  logic                         dev_we_o;
  logic [XLEN/8-1:0]            dev_be_o;
  logic [NR_DEVS-1:0]           dev_rvalid_i;
  logic [NR_DEVS*XLEN-1:0]      dev_rdata_i;

  modport slave (
    input  host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
    output host_gnt_o, host_rvalid_o, host_err_o, host_rdata_o,
    output dev_req_o, dev_addr_o, dev_wdata_o, dev_we_o, dev_be_o,
    input  dev_rvalid_i, dev_rdata_i
  );

  modport master (
    output host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
    input  host_gnt_o, host_rvalid_o, host_err_o, host_rdata_o,
    input  dev_req_o, dev_addr_o, dev_wdata_o, dev_we_o, dev_be_o,
    output dev_rvalid_i, dev_rdata_i
  );
endinterface

// File: rtl/dev_bus_xbar.sv
// Device-bus interconnect: round-robin arbitration over NR_HOSTS requesters,
// address decode onto NR_DEVS devices, one outstanding transaction, and
// error completion for decode misses and device timeouts.
module dev_bus_xbar #(
  parameter int unsigned               XLEN     = 32,
  parameter int unsigned               NR_HOSTS = 2,
  parameter int unsigned               NR_DEVS  = 3,
  parameter logic [NR_DEVS*XLEN-1:0]   DEV_BASE = {32'hCD000000, 32'hC2000000, 32'hC0000000},
  parameter logic [NR_DEVS*XLEN-1:0]   DEV_MASK = {3{32'hFF000000}},
  parameter int unsigned               TIMEOUT  = 255
) (
  input logic             clk,
  input logic             rst_ni,
  dev_bus_xbar_if.slave   bus
);

  localparam int unsigned HW = (NR_HOSTS > 1) ? $clog2(NR_HOSTS) : 1;
  localparam int unsigned DW = (NR_DEVS > 1) ? $clog2(NR_DEVS) : 1;
  localparam int unsigned BW = XLEN / 8;
  localparam logic [HW-1:0] LastInit   = HW'(NR_HOSTS - 1);
  localparam logic [7:0]    TimeoutCnt = 8'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e                state_q;
  logic [HW-1:0]         last_q, host_q;
  logic [DW-1:0]         dev_q;
  logic                  hit_q;
  logic [7:0]            cnt_q;
  logic [NR_HOSTS-1:0]   gnt_q, rvalid_q, err_q;
  logic [XLEN-1:0]       rdata_q, addr_q, wdata_q;
  logic [NR_DEVS-1:0]    dev_req_q;
  logic                  we_q;
  logic [BW-1:0]         be_q;

  logic                  any_req;
  logic [HW-1:0]         win, cand;
  int unsigned           idx;
  logic [XLEN-1:0]       win_addr;
  logic                  hit;
  logic [DW-1:0]         dec;

  // Round-robin pick: first requester after last_q, wrapping modulo NR_HOSTS.
  always_comb begin
    any_req = 1'b0;
    win     = '0;
    idx     = 0;
    cand    = '0;
    for (int unsigned i = 0; i < NR_HOSTS; i++) begin
      idx  = (32'(last_q) + 1 + i) % NR_HOSTS;
      cand = HW'(idx);
      if (!any_req && bus.host_req_i[cand]) begin
        any_req = 1'b1;
        win     = cand;
      end
    end
  end

  // Decode the winner's address; scanning downwards leaves the lowest match.
  always_comb begin
    win_addr = bus.host_addr_i[win*XLEN +: XLEN];
    hit      = 1'b0;
    dec      = '0;
    for (int d = int'(NR_DEVS) - 1; d >= 0; d--) begin
      if ((win_addr & DEV_MASK[d*XLEN +: XLEN]) == DEV_BASE[d*XLEN +: XLEN]) begin
        hit = 1'b1;
        dec = DW'(d);
      end
    end
  end

  // Transaction FSM; gnt/dev_req/rvalid are single-cycle registered pulses.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      last_q    <= LastInit;
      host_q    <= '0;
      dev_q     <= '0;
      hit_q     <= 1'b0;
      cnt_q     <= '0;
      gnt_q     <= '0;
      rvalid_q  <= '0;
      err_q     <= '0;
      rdata_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      be_q      <= '0;
      dev_req_q <= '0;
    end else begin
      gnt_q     <= '0;
      dev_req_q <= '0;
      rvalid_q  <= '0;
      err_q     <= '0;
      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            host_q     <= win;
            addr_q     <= win_addr;
            we_q       <= bus.host_we_i[win];
            be_q       <= bus.host_be_i[win*BW +: BW];
            wdata_q    <= bus.host_wdata_i[win*XLEN +: XLEN];
            hit_q      <= hit;
            dev_q      <= dec;
            gnt_q[win] <= 1'b1;
            if (hit) dev_req_q[dec] <= 1'b1;
            state_q    <= StIssue;
          end
        end
        StIssue: begin
          last_q <= host_q;
          if (hit_q) begin
            cnt_q   <= '0;
            state_q <= StWait;
          end else begin
            rdata_q          <= '0;
            rvalid_q[host_q] <= 1'b1;
            err_q[host_q]    <= 1'b1;
            state_q          <= StResp;
          end
        end
        StWait: begin
          cnt_q <= cnt_q + 8'd1;
          // A completion on the timeout cycle takes priority over the timeout.
          if (bus.dev_rvalid_i[dev_q]) begin
            rdata_q          <= bus.dev_rdata_i[dev_q*XLEN +: XLEN];
            rvalid_q[host_q] <= 1'b1;
            state_q          <= StResp;
          end else if (cnt_q + 8'd1 == TimeoutCnt) begin
            rdata_q          <= '0;
            rvalid_q[host_q] <= 1'b1;
            err_q[host_q]    <= 1'b1;
            state_q          <= StResp;
          end
        end
        StResp: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.host_gnt_o    = gnt_q;
  assign bus.host_rvalid_o = rvalid_q;
  assign bus.host_err_o    = err_q;
  assign bus.host_rdata_o  = rdata_q;
  assign bus.dev_req_o     = dev_req_q;
  assign bus.dev_addr_o    = addr_q;
  assign bus.dev_wdata_o   = wdata_q;
  assign bus.dev_we_o      = we_q;
  assign bus.dev_be_o      = be_q;

endmodule
